// File: rtl/tanimoto_comparator_wrapper.sv
// Tanimoto comparator: final decision stage of the similarity pipeline.
// Forms S = A+B, looks up the minimum intersection C required for that S in a
// loadable threshold table, and flags pairs that reach the threshold.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   i_CntA/B/C   popcounts |a|, |b| and |a AND b|
//   i_Threshold  table write data, used when i_Valid is low
//   i_Valid      high: compare A/B/C this cycle; low: load one table entry
//   o_Valid      o_Dout is valid (i_Valid delayed by 3 cycles)
//   o_Dout       1 = at or over threshold, 0 otherwise
module tanimoto_comparator_wrapper #(
  parameter int unsigned VECTOR_WIDTH = 35,
  parameter int unsigned BUS_WIDTH    = 20,
  localparam int unsigned CNT_WIDTH   = $clog2(VECTOR_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] i_CntA,
  input  logic [CNT_WIDTH-1:0] i_CntB,
  input  logic [CNT_WIDTH-1:0] i_CntC,
  input  logic [CNT_WIDTH:0]   i_Threshold,
  input  logic                 i_Valid,
  output logic                 o_Valid,
  output logic                 o_Dout
);

  localparam int unsigned SumW  = CNT_WIDTH + 1;
  localparam int unsigned Depth = 2 * VECTOR_WIDTH + 1;
  localparam int unsigned AddrW = $clog2(Depth);

  // Upstream bus width carries no logic here; only reject a degenerate value.
  if (BUS_WIDTH == 0) begin : g_bus_width_check
    $error("BUS_WIDTH must be greater than zero");
  end

  logic [SumW-1:0]      thr_mem [Depth];

  logic [AddrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic                 v1_q, v2_q;
  logic [CNT_WIDTH-1:0] c1_q, c2_q;
  logic [SumW-1:0]      s1_q, s2_q, thr2_q;
  logic [SumW-1:0]      sum_d, rd_d;
  logic [AddrW-1:0]     rd_addr;
  logic                 hit_d;

  // Next-state and combinational datapath.
  always_comb begin
    sum_d    = SumW'(i_CntA) + SumW'(i_CntB);
    wr_ptr_d = wr_ptr_q;
    if (i_Valid) begin
      wr_ptr_d = '0;
    end else if (wr_ptr_q == AddrW'(Depth - 1)) begin
      wr_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AddrW'(1);
    end
    // Out-of-table sums read as all-ones so no C can satisfy them.
    rd_addr = AddrW'(s1_q);
    rd_d    = '1;
    if (32'(s1_q) < Depth) begin
      rd_d = thr_mem[rd_addr];
    end
    // C > S cannot happen for real vectors; treat it as a miss.
    hit_d = (SumW'(c2_q) >= thr2_q) && (SumW'(c2_q) <= s2_q);
  end

  // Threshold table write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (!rst && !i_Valid) begin
      thr_mem[wr_ptr_q] <= i_Threshold;
    end
  end

  // Three-stage compare pipeline and load pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      c1_q     <= '0;
      c2_q     <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      thr2_q   <= '0;
      o_Valid  <= 1'b0;
      o_Dout   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      v1_q     <= i_Valid;
      c1_q     <= i_CntC;
      s1_q     <= sum_d;
      v2_q     <= v1_q;
      c2_q     <= c1_q;
      s2_q     <= s1_q;
      thr2_q   <= rd_d;
      o_Valid  <= v2_q;
      o_Dout   <= v2_q & hit_d;
    end
  end

endmodule

// File: tb/tb_tanimoto_comparator_wrapper.sv
module tb_tanimoto_comparator_wrapper;

  localparam int unsigned Depth = 71;

  logic       clk;
  logic       rst;
  logic [5:0] i_CntA, i_CntB, i_CntC;
  logic [6:0] i_Threshold;
  logic       i_Valid;
  logic       o_Valid, o_Dout;

  tanimoto_comparator_wrapper dut (
    .clk        (clk),
    .rst        (rst),
    .i_CntA     (i_CntA),
    .i_CntB     (i_CntB),
    .i_CntC     (i_CntC),
    .i_Threshold(i_Threshold),
    .i_Valid    (i_Valid),
    .o_Valid    (o_Valid),
    .o_Dout     (o_Dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] c;
    logic       exp;
  } vec_t;

  vec_t       vecs[13];
  logic [6:0] model_tab[Depth];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle cycle that rewrites the entry the pointer lands on with its current value.
  task automatic drive_idle(input int j);
    i_Valid     = 1'b0;
    i_CntA      = '0;
    i_CntB      = '0;
    i_CntC      = '0;
    i_Threshold = model_tab[j % Depth];
  endtask

  task automatic drive_vec(input int i);
    i_Valid = 1'b1;
    i_CntA  = vecs[i].a;
    i_CntB  = vecs[i].b;
    i_CntC  = vecs[i].c;
  endtask

  // Streams vecs[first..first+cnt-1] back to back, then drains; checks every cycle.
  task automatic run_seq(input int first, input int cnt);
    int j;
    for (int t = 0; t < cnt + 4; t++) begin
      if (t < cnt) drive_vec(first + t);
      else         drive_idle(t - cnt);
      tick();
      j = t - 2;
      if (j >= 0 && j < cnt) begin
        chk($sformatf("vec%0d_valid", first + j), o_Valid, 1'b1);
        chk($sformatf("vec%0d_dout", first + j), o_Dout, vecs[first + j].exp);
      end else begin
        chk($sformatf("seq%0d_idle_valid_t%0d", first, t), o_Valid, 1'b0);
        chk($sformatf("seq%0d_idle_dout_t%0d", first, t), o_Dout, 1'b0);
      end
    end
  endtask

  initial begin
    // Table contents k>>1: stream, boundary and out-of-range cases.
    vecs[0]  = '{a: 6'd0,  b: 6'd0,  c: 6'd0,  exp: 1'b1};
    vecs[1]  = '{a: 6'd3,  b: 6'd4,  c: 6'd3,  exp: 1'b1};
    vecs[2]  = '{a: 6'd6,  b: 6'd8,  c: 6'd5,  exp: 1'b0};
    vecs[3]  = '{a: 6'd20, b: 6'd1,  c: 6'd20, exp: 1'b1};
    vecs[4]  = '{a: 6'd6,  b: 6'd8,  c: 6'd16, exp: 1'b0};
    vecs[5]  = '{a: 6'd33, b: 6'd2,  c: 6'd17, exp: 1'b1};
    vecs[6]  = '{a: 6'd33, b: 6'd2,  c: 6'd16, exp: 1'b0};
    vecs[7]  = '{a: 6'd35, b: 6'd35, c: 6'd35, exp: 1'b1};
    vecs[8]  = '{a: 6'd63, b: 6'd8,  c: 6'd0,  exp: 1'b0};
    vecs[9]  = '{a: 6'd63, b: 6'd63, c: 6'd63, exp: 1'b0};
    // Table contents k>>2 after reload.
    vecs[10] = '{a: 6'd6,  b: 6'd8,  c: 6'd5,  exp: 1'b1};
    vecs[11] = '{a: 6'd33, b: 6'd2,  c: 6'd8,  exp: 1'b1};
    vecs[12] = '{a: 6'd33, b: 6'd2,  c: 6'd7,  exp: 1'b0};

    rst = 1'b1;
    drive_idle(0);
    i_Threshold = '0;
    tick();
    tick();
    chk("reset_valid", o_Valid, 1'b0);
    chk("reset_dout", o_Dout, 1'b0);
    rst = 1'b0;

    // Initial load: entry k = k>>1.
    for (int k = 0; k < Depth; k++) begin
      model_tab[k] = 7'(k >> 1);
      i_Valid      = 1'b0;
      i_Threshold  = model_tab[k];
      tick();
    end
    chk("load_quiet_valid", o_Valid, 1'b0);
    chk("load_quiet_dout", o_Dout, 1'b0);

    run_seq(0, 5);
    run_seq(5, 2);
    run_seq(7, 3);
    run_seq(1, 1);

    // Stream one vector, then reload k>>2 immediately behind it.
    drive_vec(3);
    tick();
    for (int k = 0; k < Depth; k++) begin
      model_tab[k] = 7'(k >> 2);
      i_Valid      = 1'b0;
      i_Threshold  = model_tab[k];
      tick();
      if (k == 1) begin
        chk("reload_inflight_valid", o_Valid, 1'b1);
        chk("reload_inflight_dout", o_Dout, 1'b1);
      end else if (k < 4) begin
        chk($sformatf("reload_quiet_valid_%0d", k), o_Valid, 1'b0);
      end
    end

    run_seq(10, 3);

    // Reset with two results in flight.
    drive_vec(1);
    tick();
    chk("midrst_pre0_valid", o_Valid, 1'b0);
    drive_vec(3);
    tick();
    chk("midrst_pre1_valid", o_Valid, 1'b0);
    rst = 1'b1;
    drive_idle(0);
    tick();
    chk("midrst_flush0_valid", o_Valid, 1'b0);
    chk("midrst_flush0_dout", o_Dout, 1'b0);
    rst = 1'b0;
    drive_idle(0);
    tick();
    chk("midrst_flush1_valid", o_Valid, 1'b0);
    chk("midrst_flush1_dout", o_Dout, 1'b0);
    drive_idle(1);
    tick();
    chk("midrst_flush2_valid", o_Valid, 1'b0);
    run_seq(10, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tanimoto_comparator_wrapper.md
Name: tanimoto_comparator_wrapper

Overview:
- Final decision stage of the Tanimoto similarity pipeline.
- Takes popcounts A=|a|, B=|b| and C=|a AND b| for a vector pair, looks up a minimum-C threshold indexed by A+B from an internal threshold table, and flags whether the pair meets the similarity threshold.
- The threshold table is loaded through i_Threshold while no data is streaming.

Parameters:
- VECTOR_WIDTH, 35, bit length of the compared fingerprint vectors. Bounds every popcount.
- BUS_WIDTH, 20, width of the upstream data bus. Informational only; no logic depends on it; must be >0.
- CNT_WIDTH, $clog2(VECTOR_WIDTH) (6 at default), derived local: popcount width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_CntA  in  CNT_WIDTH  popcount A.
- i_CntB  in  CNT_WIDTH  popcount B.
- i_CntC  in  CNT_WIDTH  popcount C, the intersection.
- i_Threshold  in  CNT_WIDTH+1  table write data: minimum C for the current write address.
- i_Valid  in  1  high: A/B/C valid this cycle (compare mode). Low: table load mode.
- o_Valid  out  1  o_Dout is valid this cycle.
- o_Dout  out  1  1 = at or over threshold, 0 = under threshold or inconsistent input.

Behaviour:
- One clock domain. Reset is synchronous and active-high. Clock and reset ports are named clk and rst.
- Threshold table:
  - DEPTH = 2*VECTOR_WIDTH+1 entries (71 at default), each CNT_WIDTH+1 bits.
  - Entry k holds the minimum C required when A+B = k.
  - Contents are not cleared by reset and are undefined until written.
- Loading:
  - Every cycle with i_Valid=0, i_Threshold is written to table[wr_ptr], then wr_ptr increments.
  - wr_ptr wraps from DEPTH-1 to 0.
  - wr_ptr returns to 0 on rst and on every cycle with i_Valid=1, so each idle gap after a stream starts a fresh load at address 0.
- Compare pipeline, fixed 3-cycle latency from an i_Valid=1 edge to o_Valid/o_Dout:
  - Stage 1: register C and the sum S = A+B (CNT_WIDTH+1 bits, no overflow); propagate the valid bit.
  - Stage 2: synchronous table read at address S; register C and S alongside. If S >= DEPTH, the read returns all-ones, so the result is always 0.
  - Stage 3: o_Dout <= (C >= table[S]) && (C <= S). o_Valid <= stage-2 valid.
  - The C <= S guard forces 0 for physically impossible inputs.
- o_Valid is i_Valid delayed by exactly 3 cycles.
- Back-to-back valid inputs give one result per cycle; there is no stall or backpressure.
- When o_Valid=0, o_Dout holds 0.
- Read/write collision: writes only occur while i_Valid=0, but in-flight reads may overlap them. Reads return the old (pre-write) data.
- Reset:
  - o_Valid=0, o_Dout=0, all pipeline valid bits cleared, wr_ptr=0.
  - A reset mid-stream discards all in-flight results; no o_Valid appears for them.
- Equality counts as over threshold (C == table[S] gives 1).

Test Plan:
- Load: after reset, hold i_Valid=0 and drive i_Threshold = k>>1 on cycle k for k=0..70. The table must read back so that each entry k = k>>1.
- Stream A/B/C = (0,0,0), (3,4,3), (6,8,5), (20,1,20), (6,8,16) on consecutive cycles with i_Valid=1. Required response starts exactly 3 cycles later, one per cycle: o_Valid=1 with o_Dout = 1, 1, 0, 1, 0. The last 0 comes from the C>S guard.
- Boundary: A=33, B=2, C=17 (S=35, threshold 17) -> o_Dout=1. C=16 -> o_Dout=0.
- Latency/gaps: single isolated valid pulse -> exactly one o_Valid pulse 3 cycles later. o_Valid=0 and o_Dout=0 otherwise.
- Reload: after a stream, drop i_Valid and write entries k = k>>2 starting at address 0. Re-run A/B/C = (6,8,5) -> o_Dout=1, showing the pointer restarted and the new contents are in use.
- Reset mid-stream: assert rst for 1 cycle while 2 results are in flight. No o_Valid for them; the next valid input produces a result 3 cycles later.
